// File: rtl/test_console.sv
// Memory-mapped bench console: TX character FIFO, status, exit-code latch and
// optional cycle counter (enabled with `define CYCLE_COUNT_EN).
module test_console #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_7F00,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic        hit,
    output logic [31:0] read_data,
    output logic        char_valid,
    output logic [7:0]  char_data,
    input  logic        char_ready,
    output logic        halted,
    output logic [31:0] exit_code
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_EXIT   = 2'd2;
    localparam logic [1:0] OFF_CYCLES = 2'd3;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             r_halted;
    logic [31:0]      r_exit_code;

    logic [1:0]  w_off;
    logic        w_store;
    logic        w_tx_store;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_push;
    logic        w_drop;
    logic        w_clr_ovf;
    logic        w_exit_store;
    logic [7:0]  w_count8;
    logic [31:0] w_cycles;
    logic        w_unused;

    // Byte lane select bits carry no meaning for this word-only window.
    assign w_unused = ^addr[1:0];

    assign hit      = (addr[31:4] == BASE_ADDR[31:4]);
    assign w_off    = addr[3:2];
    // A cycle with both strobes is treated purely as a load.
    assign w_store  = hit && mem_write && !mem_read;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop    = !w_empty && char_ready;

    assign w_tx_store   = w_store && (w_off == OFF_TXDATA) && !r_halted;
    assign w_push       = w_tx_store && (!w_full || w_pop);
    assign w_drop       = w_tx_store && w_full && !w_pop;
    assign w_clr_ovf    = w_store && (w_off == OFF_STATUS) && write_data[2];
    assign w_exit_store = w_store && (w_off == OFF_EXIT) && !r_halted;

    assign w_count8 = {{(8 - CNT_W){1'b0}}, r_count};

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wptr] <= write_data[7:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A fresh overflow in the same cycle as a clear request takes priority.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (w_clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_halted    <= 1'b0;
            r_exit_code <= '0;
        end else if (w_exit_store) begin
            r_halted    <= 1'b1;
            r_exit_code <= write_data;
        end
    end

`ifdef CYCLE_COUNT_EN
    logic [31:0] r_cycles;

    // Keeps counting through the halting edge, then freezes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cycles <= '0;
        end else if (!r_halted) begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    assign w_cycles = r_cycles;
`else
    assign w_cycles = '0;
`endif

    always_comb begin
        read_data = '0;
        if (hit && mem_read) begin
            unique case (w_off)
                OFF_STATUS: read_data = {16'b0, w_count8, 5'b0, r_overflow, w_empty, w_full};
                OFF_CYCLES: read_data = w_cycles;
                OFF_TXDATA: read_data = '0;
                OFF_EXIT:   read_data = '0;
                default:    read_data = '0;
            endcase
        end
    end

    assign char_valid = !w_empty;
    assign char_data  = r_mem[r_rptr];
    assign halted     = r_halted;
    assign exit_code  = r_exit_code;

endmodule

// File: doc/test_console.md
TEST_CONSOLE -- requirements
Module: test_console

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_7F00, word-aligned base of the 16-byte register window.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, character FIFO entries, power of two, 2..64.
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mem_write  input  1  CPU store strobe.
REQ-006 SHALL have port mem_read  input  1  CPU load strobe.
REQ-007 SHALL have port addr  input  32  CPU byte address.
REQ-008 SHALL have port write_data  input  32  CPU store data.
REQ-009 SHALL have port hit  output  1  combinational; 1 when addr[31:4] equals BASE_ADDR[31:4].
REQ-010 SHALL have port read_data  output  32  combinational load data; 0 when hit=0 or mem_read=0.
REQ-011 SHALL have port char_valid  output  1  FIFO head valid toward the bench.
REQ-012 SHALL have port char_data  output  8  FIFO head character.
REQ-013 SHALL have port char_ready  input  1  bench consumes the head.
REQ-014 SHALL have port halted  output  1  program has written the exit code.
REQ-015 SHALL have port exit_code  output  32  value captured at halt.

Function
REQ-016 SHALL decode offsets addr[3:2]: 0 TXDATA, 1 STATUS, 2 EXIT, 3 CYCLES; addr[1:0] ignored.
REQ-017 SHALL push write_data[7:0] on a TXDATA store with hit=1, halted=0, and an accepted push.
REQ-018 SHALL accept a push when count<FIFO_DEPTH, or when full with a pop in the same cycle.
REQ-019 SHALL drop a refused push, leaving FIFO unchanged, and set sticky overflow.
REQ-020 SHALL pop on a rising edge where char_valid=1 and char_ready=1; char_valid=(count!=0).
REQ-021 SHALL on simultaneous push and pop keep count unchanged and preserve FIFO order.
REQ-022 SHALL wrap read/write pointers modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
REQ-023 SHALL return STATUS read_data = {16'b0, count[7:0], 5'b0, overflow, empty, full}.
REQ-024 SHALL clear overflow on a STATUS store with write_data[2]=1; a same-cycle new overflow wins.
REQ-025 SHALL on the first EXIT store set halted=1 and exit_code=write_data, visible the next cycle.
REQ-026 SHALL ignore EXIT and TXDATA stores while halted=1; FIFO continues to drain.
REQ-027 SHALL return 0 on loads of TXDATA and EXIT.
REQ-028 SHALL ignore stores when hit=0, and ignore a cycle with both mem_read and mem_write as a load only.

Reset
REQ-029 SHALL on reset=1 clear, asynchronously, FIFO pointers, count, overflow, halted, exit_code and cycle counter.
REQ-030 SHALL drive char_valid=0, halted=0, exit_code=0 during and immediately after reset.
REQ-031 SHALL discard buffered characters when reset asserts mid-operation.

Configuration
REQ-032 SHALL, with CYCLE_COUNT_EN defined, keep a 32-bit counter incrementing every cycle while halted=0 and wrapping at 2^32-1 to 0.
REQ-033 SHALL with CYCLE_COUNT_EN make the CYCLES load return the counter, frozen from the halt cycle onward.
REQ-034 SHALL, without CYCLE_COUNT_EN, have no counter flops, and the CYCLES load SHALL return 0.

Verification
REQ-035 SHALL cover: reset, then store 0x48 and 0x69 to TXDATA, char_ready=1 -> char_data 0x48 then 0x69, char_valid low after.
REQ-036 SHALL cover: char_ready=0, 9 TXDATA stores -> first 8 buffered, STATUS reads 0x0000_0805, 9th char lost.
REQ-037 SHALL cover: FIFO full, store with char_ready=1 same cycle -> push accepted, count stays 8, overflow stays 0.
REQ-038 SHALL cover: store 0x0000_0000 then 0x0000_0001 to EXIT -> halted=1 next cycle, exit_code stays 0.
REQ-039 SHALL cover: CYCLE_COUNT_EN defined, CYCLES load 10 cycles after reset release -> 10; after halt, value constant.
REQ-040 SHALL cover: reset pulse with 3 chars buffered and halted=1 -> char_valid=0, halted=0, STATUS 0x0000_0002.
